// File: rtl/led_ind_pkg.sv
// Purpose : shared mode/state encodings for the LED indication driver.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package led_ind_pkg;

  // Indication modes as presented on the mode input.
  localparam logic [1:0] MODE_OFF  = 2'd0;
  localparam logic [1:0] MODE_ON   = 2'd1;
  localparam logic [1:0] MODE_SLOW = 2'd2;
  localparam logic [1:0] MODE_FAST = 2'd3;

  // Pulse counter width; covers bursts of up to 15 flash pairs.
  localparam int PULSE_W = 4;

  typedef enum logic [1:0] {
    PAT     = 2'd0,
    ACK_ON  = 2'd1,
    ACK_OFF = 2'd2
  } state_t;

  // LED level when a pattern (re)starts from phase 0: blink modes start lit.
  function automatic logic pat_start_level(input logic [1:0] m);
    return (m != MODE_OFF);
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Purpose : phase counter with clear and run-time half-period limit.
// Latency : tc is combinational from the count; the count updates every clk.
// Backpr. : none; free-running unless cleared.
//
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : force the count back to 0 on the next edge
//   limit    : half-period length in cycles (>=1); one extra bit so a limit
//              of 2**CNT_W is still representable
//   tc       : high while the count equals limit-1; the count wraps to 0
module blink_timer #(
  parameter int CNT_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [CNT_W:0]   limit,
  output logic             tc
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_last;

  assign w_last = limit - (CNT_W+1)'(1);
  assign tc     = ({1'b0, r_cnt} == w_last);

  // Wrap by compare-and-clear, never by overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr || tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_ind_ctl.sv
// Purpose : drives one LED with off/on/slow/fast patterns plus ack flash bursts.
// Latency : mode change visible on led two edges after mode is first sampled; ack one edge.
// Backpr. : none; a new ack restarts the burst, nothing is queued.
//
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   mode     : 0 off, 1 on, 2 slow blink, 3 fast blink
//   ack      : single-cycle flash-burst request
//   led      : registered LED drive, 1 = lit
//   busy     : registered, high for the whole flash burst
module led_ind_ctl
  import led_ind_pkg::*;
#(
  parameter int SLOW_HALF  = 25_000_000,
  parameter int FAST_HALF  = 6_250_000,
  parameter int ACK_HALF   = 2_500_000,
  parameter int ACK_PULSES = 3,
  parameter int CNT_W      = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       ack,
  output logic       led,
  output logic       busy
);

  localparam logic [CNT_W:0]   SLOW_LIM  = (CNT_W+1)'(SLOW_HALF);
  localparam logic [CNT_W:0]   FAST_LIM  = (CNT_W+1)'(FAST_HALF);
  localparam logic [CNT_W:0]   ACK_LIM   = (CNT_W+1)'(ACK_HALF);
  localparam logic [PULSE_W-1:0] PULSE_END = PULSE_W'(ACK_PULSES);

  state_t             r_state;
  state_t             w_nxt_state;
  logic [1:0]         r_mode_q;
  logic               r_mode_chg;
  logic               r_led;
  logic               r_busy;
  logic [PULSE_W-1:0] r_pulse;

  logic               w_nxt_led;
  logic               w_nxt_busy;
  logic [PULSE_W-1:0] w_nxt_pulse;
  logic [PULSE_W-1:0] w_pulse_inc;
  logic               w_clr;
  logic               w_tc;
  logic [CNT_W:0]     w_limit;

  // One timer serves both the pattern and the flash phases.
  assign w_limit = (r_state != PAT)          ? ACK_LIM  :
                   (r_mode_q == MODE_FAST)   ? FAST_LIM : SLOW_LIM;

  blink_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_clr),
    .limit (w_limit),
    .tc    (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= PAT;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_led   = r_led;
    w_nxt_busy  = r_busy;
    w_nxt_pulse = r_pulse;
    w_clr       = 1'b0;
    w_pulse_inc = r_pulse + PULSE_W'(1);

    if (ack) begin
      // Ack wins over everything, including a burst already running.
      w_nxt_state = ACK_ON;
      w_nxt_led   = 1'b1;
      w_nxt_busy  = 1'b1;
      w_nxt_pulse = '0;
      w_clr       = 1'b1;
    end else begin
      case (r_state)
        PAT: begin
          w_nxt_busy = 1'b0;
          if (r_mode_chg) begin
            // mode_q took a new value last edge: restart from phase 0.
            w_clr     = 1'b1;
            w_nxt_led = pat_start_level(r_mode_q);
          end else begin
            case (r_mode_q)
              MODE_OFF: w_nxt_led = 1'b0;
              MODE_ON:  w_nxt_led = 1'b1;
              default:  if (w_tc) w_nxt_led = ~r_led;
            endcase
          end
        end
        ACK_ON: begin
          if (w_tc) begin
            w_nxt_state = ACK_OFF;
            w_nxt_led   = 1'b0;
          end
        end
        ACK_OFF: begin
          if (w_tc) begin
            if (w_pulse_inc == PULSE_END) begin
              // Burst done: resume the latest mode from phase 0.
              w_nxt_state = PAT;
              w_nxt_busy  = 1'b0;
              w_nxt_pulse = '0;
              w_clr       = 1'b1;
              w_nxt_led   = pat_start_level(r_mode_q);
            end else begin
              w_nxt_state = ACK_ON;
              w_nxt_led   = 1'b1;
              w_nxt_pulse = w_pulse_inc;
            end
          end
        end
        default: begin
          w_nxt_state = PAT;
          w_nxt_led   = 1'b0;
          w_nxt_busy  = 1'b0;
          w_nxt_pulse = '0;
          w_clr       = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode_q   <= MODE_OFF;
      r_mode_chg <= 1'b0;
      r_led      <= 1'b0;
      r_busy     <= 1'b0;
      r_pulse    <= '0;
    end else begin
      r_mode_q   <= mode;
      r_mode_chg <= (mode != r_mode_q);
      r_led      <= w_nxt_led;
      r_busy     <= w_nxt_busy;
      r_pulse    <= w_nxt_pulse;
    end
  end

  assign led  = r_led;
  assign busy = r_busy;

endmodule

// File: tb/tb_led_ind_ctl.sv
// Purpose : self-checking bench for led_ind_ctl with short timing parameters.
// Latency : expectations are pushed at the clock edge and compared on the next falling edge.
// Backpr. : n/a.
module tb_led_ind_ctl;

  typedef struct {
    logic [1:0] mode;
    logic       ack;
    logic       led;
    logic       busy;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic       ack;
  logic       led;
  logic       busy;

  int n_checks;
  int n_errors;

  vec_t       vecs[$];
  logic [1:0] sb_q[$];
  int         sb_idx[$];

  led_ind_ctl #(
    .SLOW_HALF  (8),
    .FAST_HALF  (2),
    .ACK_HALF   (3),
    .ACK_PULSES (2),
    .CNT_W      (4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .ack  (ack),
    .led  (led),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add_run(input logic [1:0] m, input logic a, input logic l,
                         input logic b, input int n);
    vec_t v;
    v.mode = m;
    v.ack  = a;
    v.led  = l;
    v.busy = b;
    repeat (n) vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: outputs produced by the last edge are compared here.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      logic [1:0] exp_v;
      int         idx;
      exp_v = sb_q.pop_front();
      idx   = sb_idx.pop_front();
      n_checks++;
      if ({led, busy} !== exp_v) begin
        n_errors++;
        $display("FAIL vec[%0d] mode=%0d ack=%0b: led,busy=%b%b expected %b%b",
                 idx, vecs[idx].mode, vecs[idx].ack, led, busy, exp_v[1], exp_v[0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Each record: inputs held across one edge, outputs expected after it.
    // Off for 50 cycles after reset.
    add_run(2'd0, 1'b0, 1'b0, 1'b0, 50);
    // 0 -> 1: register loads, lit one edge later, steady for 100.
    add_run(2'd1, 1'b0, 1'b0, 1'b0, 1);
    add_run(2'd1, 1'b0, 1'b1, 1'b0, 100);
    // Back to off.
    add_run(2'd0, 1'b0, 1'b1, 1'b0, 1);
    add_run(2'd0, 1'b0, 1'b0, 1'b0, 2);
    // 0 -> 2: 8 high, 8 low, then switch to 3 three cycles into the next high.
    add_run(2'd2, 1'b0, 1'b0, 1'b0, 1);
    add_run(2'd2, 1'b0, 1'b1, 1'b0, 8);
    add_run(2'd2, 1'b0, 1'b0, 1'b0, 8);
    add_run(2'd2, 1'b0, 1'b1, 1'b0, 3);
    add_run(2'd3, 1'b0, 1'b1, 1'b0, 1);
    for (int k = 0; k < 3; k++) begin
      add_run(2'd3, 1'b0, 1'b1, 1'b0, 2);
      add_run(2'd3, 1'b0, 1'b0, 1'b0, 2);
    end
    // Steady on, then one ack: 12 busy cycles, 1,1,1,0,0,0 twice.
    add_run(2'd1, 1'b0, 1'b1, 1'b0, 5);
    add_run(2'd1, 1'b1, 1'b1, 1'b1, 1);
    add_run(2'd1, 1'b0, 1'b1, 1'b1, 2);
    add_run(2'd1, 1'b0, 1'b0, 1'b1, 3);
    add_run(2'd1, 1'b0, 1'b1, 1'b1, 3);
    add_run(2'd1, 1'b0, 1'b0, 1'b1, 3);
    add_run(2'd1, 1'b0, 1'b1, 1'b0, 3);
    // Slow blink, ack, re-ack 4 cycles later, mode 3 during the burst.
    add_run(2'd2, 1'b0, 1'b1, 1'b0, 2);
    add_run(2'd2, 1'b1, 1'b1, 1'b1, 1);
    add_run(2'd2, 1'b0, 1'b1, 1'b1, 2);
    add_run(2'd2, 1'b0, 1'b0, 1'b1, 1);
    add_run(2'd2, 1'b1, 1'b1, 1'b1, 1);
    add_run(2'd3, 1'b0, 1'b1, 1'b1, 2);
    add_run(2'd3, 1'b0, 1'b0, 1'b1, 3);
    add_run(2'd3, 1'b0, 1'b1, 1'b1, 3);
    add_run(2'd3, 1'b0, 1'b0, 1'b1, 3);
    add_run(2'd3, 1'b0, 1'b1, 1'b0, 2);
    add_run(2'd3, 1'b0, 1'b0, 1'b0, 2);
    add_run(2'd3, 1'b0, 1'b1, 1'b0, 2);

    // Reset with mode=3 and ack=1 must hold everything dark.
    rst  = 1'b1;
    mode = 2'd3;
    ack  = 1'b1;
    #1;
    chk("reset_led_async", led, 1'b0);
    chk("reset_busy_async", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_led", led, 1'b0);
    chk("reset_busy", busy, 1'b0);
    mode = 2'd0;
    ack  = 1'b0;
    rst  = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      mode = vecs[i].mode;
      ack  = vecs[i].ack;
      @(posedge clk);
      sb_q.push_back({vecs[i].led, vecs[i].busy});
      sb_idx.push_back(i);
    end
    @(negedge clk);
    #1;

    // Reset in cycle 5 of a burst aborts it immediately.
    @(negedge clk);
    mode = 2'd3;
    ack  = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    chk("burst5_busy", busy, 1'b1);
    chk("burst5_led", led, 1'b0);
    rst = 1'b1;
    #1;
    chk("midburst_rst_busy", busy, 1'b0);
    chk("midburst_rst_led", led, 1'b0);
    @(negedge clk);
    mode = 2'd1;
    @(negedge clk);
    chk("in_rst_led", led, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("mode_load_led", led, 1'b0);
    @(negedge clk);
    chk("post_rst_on_led", led, 1'b1);
    chk("post_rst_on_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
